// File: rtl/io_frame_tx.sv
// io_frame_tx: transmit-side byte framer for the 8-bit off-chip IO bus.
// Buffers 16-bit words (ctrl in [15:8], data in [7:0]) in a small FIFO and
// emits each one as a four-byte frame: sync, ctrl, data, ctrl^data. Every
// byte is held for HOLD_CYCLES clocks. Frames run only while mode_sel_i is 0.
module io_frame_tx #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter logic [7:0]  IDLE_BYTE   = 8'h00,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mode_sel_i,
    input  logic [15:0] word_in_i,
    input  logic        word_valid_i,
    output logic        word_ready_o,
    output logic [7:0]  io_out_o,
    output logic        io_oe_o,
    output logic        byte_stb_o,
    output logic        frame_done_o,
    output logic [7:0]  frame_cnt_o
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [HW-1:0] HOLD_ZERO = HW'(1'b0);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1'b1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_CTRL = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } state_e;

    // Frame checksum: XOR of the control and data bytes.
    function automatic logic [7:0] csum_f(input logic [15:0] w);
        return w[15:8] ^ w[7:0];
    endfunction

    // FIFO storage and bookkeeping
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          fifo_empty_s;
    logic          push_s;
    logic          pop_s;

    // Framer state
    state_e        state_q;
    state_e        state_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic          hold_last_s;
    logic          frame_inc_s;
    logic [15:0]   frame_q;

    // Registered outputs
    logic          word_ready_q;
    logic          word_ready_d;
    logic [7:0]    io_out_q;
    logic [7:0]    io_out_d;
    logic          io_oe_q;
    logic          byte_stb_q;
    logic          byte_stb_d;
    logic          frame_done_q;
    logic          frame_done_d;
    logic [7:0]    frame_cnt_q;
    logic [7:0]    frame_cnt_d;

    assign fifo_empty_s = (count_q == CNT_ZERO);
    assign push_s       = word_valid_i & word_ready_q;
    assign hold_last_s  = (hold_q == HOLD_LAST);

    // FIFO occupancy after the current edge; drives the registered ready flag.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (count_d < DEPTH_C) begin
            word_ready_d = 1'b1;
        end else begin
            word_ready_d = 1'b0;
        end
    end

    // FIFO pointers and occupancy; contents are lost on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

    // FIFO data array; pure datapath, validity is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= word_in_i;
        end
    end

    // Capture the head word when a frame starts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_q <= 16'h0000;
        end else if (pop_s) begin
            frame_q <= mem_q[rd_ptr_q];
        end
    end

    // FSM state and hold counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            hold_q  <= HOLD_ZERO;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // FSM next state: byte sequencing, FIFO pop, abort on RX mode.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        pop_s       = 1'b0;
        frame_inc_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hold_d = HOLD_ZERO;
                if (!mode_sel_i && !fifo_empty_s) begin
                    state_d = ST_SYNC;
                    pop_s   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SYNC, ST_CTRL, ST_DATA: begin
                if (mode_sel_i) begin
                    state_d = ST_IDLE;
                    hold_d  = HOLD_ZERO;
                end else if (hold_last_s) begin
                    hold_d = HOLD_ZERO;
                    if (state_q == ST_SYNC) begin
                        state_d = ST_CTRL;
                    end else if (state_q == ST_CTRL) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_CSUM;
                    end
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            ST_CSUM: begin
                if (mode_sel_i) begin
                    state_d = ST_IDLE;
                    hold_d  = HOLD_ZERO;
                end else if (hold_last_s) begin
                    hold_d      = HOLD_ZERO;
                    frame_inc_s = 1'b1;
                    if (!fifo_empty_s) begin
                        state_d = ST_SYNC;
                        pop_s   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = HOLD_ZERO;
            end
        endcase
    end

    // Output decode from the upcoming state so every output is registered.
    always_comb begin
        io_out_d     = IDLE_BYTE;
        byte_stb_d   = 1'b0;
        frame_done_d = 1'b0;
        case (state_d)
            ST_IDLE: io_out_d = IDLE_BYTE;
            ST_SYNC: io_out_d = SYNC_BYTE;
            ST_CTRL: io_out_d = frame_q[15:8];
            ST_DATA: io_out_d = frame_q[7:0];
            ST_CSUM: io_out_d = csum_f(frame_q);
            default: io_out_d = IDLE_BYTE;
        endcase
        if ((state_d != ST_IDLE) && (hold_d == HOLD_ZERO)) begin
            byte_stb_d = 1'b1;
        end else begin
            byte_stb_d = 1'b0;
        end
        if ((state_d == ST_CSUM) && (hold_d == HOLD_LAST)) begin
            frame_done_d = 1'b1;
        end else begin
            frame_done_d = 1'b0;
        end
        if (frame_inc_s) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            io_out_q     <= IDLE_BYTE;
            io_oe_q      <= 1'b0;
            byte_stb_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
            word_ready_q <= 1'b0;
        end else begin
            io_out_q     <= io_out_d;
            io_oe_q      <= ~mode_sel_i;
            byte_stb_q   <= byte_stb_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            word_ready_q <= word_ready_d;
        end
    end

    assign word_ready_o = word_ready_q;
    assign io_out_o     = io_out_q;
    assign io_oe_o      = io_oe_q;
    assign byte_stb_o   = byte_stb_q;
    assign frame_done_o = frame_done_q;
    assign frame_cnt_o  = frame_cnt_q;

endmodule
